// File: rtl/core_mem_arb_if.sv
// core_mem_arb_if
//   Bundles the three buses around the core memory arbiter: the instruction
//   fetch port (if_*), the load/store port (ls_*) and the single shared memory
//   port (mem_*). Signal names keep their _i/_o suffix as seen from the
//   arbiter.
//   slave  : arbiter side (drives *_o, samples *_i)
//   master : core + memory side (drives *_i, samples *_o)
interface core_mem_arb_if #(
   parameter int ADDR_W = 64
);
   // instruction fetch unit
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_flush_i;
   logic              if_ready_o;
   logic              if_rvalid_o;
   logic [31:0]       if_rdata_o;
   // load/store unit
   logic              ls_req_i;
   logic              ls_we_i;
   logic [ADDR_W-1:0] ls_addr_i;
   logic [63:0]       ls_wdata_i;
   logic [7:0]        ls_wmask_i;
   logic              ls_ready_o;
   logic              ls_rvalid_o;
   logic [63:0]       ls_rdata_o;
   // shared memory port
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [63:0]       mem_wdata_o;
   logic [7:0]        mem_wmask_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [63:0]       mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i, if_flush_i,
      output if_ready_o, if_rvalid_o, if_rdata_o,
      input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
      output ls_ready_o, ls_rvalid_o, ls_rdata_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport master (
      output if_req_i, if_addr_i, if_flush_i,
      input  if_ready_o, if_rvalid_o, if_rdata_o,
      output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
      input  ls_ready_o, ls_rvalid_o, ls_rdata_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/core_mem_arb.sv
// core_mem_arb
//   Arbitrates the IFU and LSU onto one memory port with at most one
//   transaction outstanding. LSU has priority; after STARVE_MAX consecutive
//   contested LSU grants the IFU wins the next arbitration. A flush during an
//   outstanding fetch lets the bus transaction finish but suppresses its
//   response.
//   Ports:
//     clk  - core clock, all state on rising edge
//     rst  - synchronous active-high reset
//     bus  - core_mem_arb_if.slave: if_* fetch port, ls_* load/store port,
//            mem_* shared memory port (req/gnt then rvalid)
module core_mem_arb #(
   parameter int ADDR_W     = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic           clk,
   input  logic           rst,
   core_mem_arb_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e            state_q, state_d;
   logic              owner_ls_q, owner_ls_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [7:0]        wmask_q, wmask_d;
   logic [2:0]        streak_q, streak_d;
   logic              drop_q, drop_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              ls_rvalid_q, ls_rvalid_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [63:0]       ls_rdata_q, ls_rdata_d;
   logic              if_grant, ls_grant;
   logic              ifu_ok, starved, in_req;

   // A flushing IFU cannot be granted, so its starvation privilege is
   // meaningless that cycle and the LSU keeps winning.
   assign ifu_ok  = bus.if_req_i && !bus.if_flush_i;
   assign starved = (streak_q == 3'(STARVE_MAX));
   assign in_req  = (state_q == REQ);

   always_comb begin
      state_d     = state_q;
      owner_ls_d  = owner_ls_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      streak_d    = streak_q;
      drop_d      = drop_q;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_grant    = 1'b0;
      ls_grant    = 1'b0;

      case (state_q)
         IDLE: begin
            // Grants are suppressed while reset is held so every output is
            // quiet during reset.
            if (!rst) begin
               if (ifu_ok && (!bus.ls_req_i || starved)) begin
                  if_grant = 1'b1;
               end else if (bus.ls_req_i) begin
                  ls_grant = 1'b1;
               end
            end
            if (ls_grant) begin
               owner_ls_d = 1'b1;
               addr_d     = bus.ls_addr_i;
               we_d       = bus.ls_we_i;
               wdata_d    = bus.ls_we_i ? bus.ls_wdata_i : 64'd0;
               wmask_d    = bus.ls_we_i ? bus.ls_wmask_i : 8'd0;
               // Only grants that beat a waiting IFU count toward starvation.
               if (bus.if_req_i && !starved) begin
                  streak_d = streak_q + 3'd1;
               end
               state_d = REQ;
            end else if (if_grant) begin
               owner_ls_d = 1'b0;
               addr_d     = bus.if_addr_i;
               we_d       = 1'b0;
               wdata_d    = 64'd0;
               wmask_d    = 8'd0;
               streak_d   = 3'd0;
               drop_d     = 1'b0;
               state_d    = REQ;
            end
         end

         REQ: begin
            if (!owner_ls_q && bus.if_flush_i) begin
               drop_d = 1'b1;
            end
            if (bus.mem_gnt_i) begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (bus.mem_rvalid_i) begin
               state_d = IDLE;
               drop_d  = 1'b0;
               if (owner_ls_q) begin
                  ls_rvalid_d = 1'b1;
                  ls_rdata_d  = bus.mem_rdata_i;
               end else if (!(drop_q || bus.if_flush_i)) begin
                  // A flush arriving together with the data still kills it.
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = addr_q[2] ? bus.mem_rdata_i[63:32]
                                          : bus.mem_rdata_i[31:0];
               end
            end else if (!owner_ls_q && bus.if_flush_i) begin
               drop_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         streak_q    <= 3'd0;
         drop_q      <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= 32'd0;
         ls_rdata_q  <= 64'd0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         drop_q      <= drop_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
      end
   end

   // Request payload needs no reset: it is only visible on the bus in REQ.
   always_ff @(posedge clk) begin
      owner_ls_q <= owner_ls_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
   end

   assign bus.if_ready_o  = if_grant;
   assign bus.ls_ready_o  = ls_grant;
   assign bus.if_rvalid_o = if_rvalid_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.ls_rvalid_o = ls_rvalid_q;
   assign bus.ls_rdata_o  = ls_rdata_q;

   assign bus.mem_req_o   = in_req;
   assign bus.mem_we_o    = in_req ? we_q : 1'b0;
   assign bus.mem_addr_o  = in_req ? addr_q : '0;
   assign bus.mem_wdata_o = in_req ? wdata_q : 64'd0;
   assign bus.mem_wmask_o = in_req ? wmask_q : 8'd0;

endmodule

// File: tb/tb_core_mem_arb.sv
module tb_core_mem_arb;
   localparam int ADDR_W     = 64;
   localparam int STARVE_MAX = 4;
   localparam int NCYC       = 3000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   core_mem_arb_if #(.ADDR_W(ADDR_W)) bus ();

   core_mem_arb #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        ls;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      int          acc;
   } txn_t;

   typedef struct {
      logic        ls;
      logic        st;
      logic [63:0] data;
      int          acc;
   } resp_t;

   int n_checks = 0;
   int n_errors = 0;
   int mcyc     = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, mcyc);
      end
   endtask

   function automatic logic [63:0] mem_data(input logic [63:0] a);
      if (a == 64'h8000_0004) return 64'h1111_2222_3333_4444;
      return {a[31:0] ^ 32'h5A5A_0F0F, a[63:32] ^ a[31:0] ^ 32'h1234_5678};
   endfunction

   // ---------------- reference model + scoreboard (monitor) ----------------
   resp_t       exp_q[$];
   resp_t       mr;
   txn_t        cur;
   logic        busy = 0, ph_req = 0, ph_wait = 0, drop = 0, resp_due = 0;
   int          streak = 0;
   logic [31:0] exp_if_rdata = '0;
   logic [63:0] exp_ls_rdata = '0;
   logic        ls_last_ok = 1, post_rst = 0;
   logic        if_acc_f = 0, ls_acc_f = 0;
   logic        e_if, e_ls, ifu_ok;
   int          if_done = 0, ls_done = 0, first_lat = -1;
   logic [31:0] first_if_data = '0;
   logic        got_first = 0;

   always @(negedge clk) begin
      mcyc++;
      if (post_rst) begin
         chk("rst_mem_bus", {bus.mem_we_o, bus.mem_wmask_o, |bus.mem_addr_o, |bus.mem_wdata_o}, 0);
      end

      if (resp_due) begin
         mr = exp_q.pop_front();
         chk("rvalid_owner", {bus.if_rvalid_o, bus.ls_rvalid_o}, mr.ls ? 2'b01 : 2'b10);
         chk("latency_min", (mcyc - mr.acc) >= 3, 1);
         if (mr.ls) begin
            ls_done++;
            if (mr.st) ls_last_ok = 0;
            else begin exp_ls_rdata = mr.data; ls_last_ok = 1; end
         end else begin
            if_done++;
            exp_if_rdata = mr.data[31:0];
            if (!got_first) begin
               got_first     = 1;
               first_if_data = bus.if_rdata_o;
               first_lat     = mcyc - mr.acc;
            end
         end
         resp_due = 0;
      end else begin
         chk("no_rvalid", {bus.if_rvalid_o, bus.ls_rvalid_o}, 2'b00);
      end
      chk("if_rdata", bus.if_rdata_o, exp_if_rdata);
      if (ls_last_ok) chk("ls_rdata", bus.ls_rdata_o, exp_ls_rdata);

      if (ph_req) begin
         chk("mem_req", bus.mem_req_o, 1);
         chk("mem_addr", bus.mem_addr_o, cur.addr);
         chk("mem_we", bus.mem_we_o, cur.we);
         chk("mem_wdata", bus.mem_wdata_o, cur.wdata);
         chk("mem_wmask", bus.mem_wmask_o, cur.wmask);
      end else begin
         chk("mem_req_idle", bus.mem_req_o, 0);
      end

      // Arbitration: LSU first, unless the eligible IFU has been passed over
      // STARVE_MAX times in a row.
      e_if = 0; e_ls = 0;
      if (!rst && !busy) begin
         ifu_ok = bus.if_req_i && !bus.if_flush_i;
         e_if   = ifu_ok && (!bus.ls_req_i || streak >= STARVE_MAX);
         e_ls   = bus.ls_req_i && !e_if;
      end
      chk("if_ready", bus.if_ready_o, e_if);
      chk("ls_ready", bus.ls_ready_o, e_ls);
      if_acc_f = bus.if_ready_o && bus.if_req_i;
      ls_acc_f = bus.ls_ready_o && bus.ls_req_i;

      if (rst) begin
         busy = 0; ph_req = 0; ph_wait = 0; drop = 0; streak = 0; resp_due = 0;
         exp_q.delete();
         exp_if_rdata = '0; exp_ls_rdata = '0; ls_last_ok = 1; post_rst = 1;
      end else begin
         post_rst = 0;
         if (busy && !cur.ls && bus.if_flush_i) drop = 1;
         if (ph_req && bus.mem_gnt_i) begin
            ph_req = 0; ph_wait = 1;
         end else if (ph_wait && bus.mem_rvalid_i) begin
            ph_wait = 0; busy = 0;
            if (cur.ls || !drop) begin
               mr.ls   = cur.ls;
               mr.st   = cur.we;
               mr.acc  = cur.acc;
               mr.data = cur.ls ? bus.mem_rdata_i
                       : (cur.addr[2] ? {32'd0, bus.mem_rdata_i[63:32]} : {32'd0, bus.mem_rdata_i[31:0]});
               exp_q.push_back(mr);
               resp_due = 1;
            end
            drop = 0;
         end
         if (e_if || e_ls) begin
            cur.ls    = e_ls;
            cur.we    = e_ls && bus.ls_we_i;
            cur.addr  = e_ls ? bus.ls_addr_i : bus.if_addr_i;
            cur.wdata = cur.we ? bus.ls_wdata_i : 64'd0;
            cur.wmask = cur.we ? bus.ls_wmask_i : 8'd0;
            cur.acc   = mcyc;
            busy = 1; ph_req = 1;
            if (e_if) streak = 0;
            else if (bus.if_req_i && streak < STARVE_MAX) streak++;
         end
      end
   end

   // ---------------- stimulus: IFU, LSU, memory, reset ----------------
   logic        if_pend = 0, ls_pend = 0, first_fetch = 1, first_store = 1;
   logic        m_busy = 0;
   int          m_cnt = 0, g_cnt = 0, phase = 0, rst_hold = 0;
   logic [63:0] m_addr, a;

   function automatic int gnt_delay(input int ph);
      if (ph == 0) return 0;
      if (ph == 1) return $urandom_range(0, 1);
      return $urandom_range(0, 5);
   endfunction

   initial begin
      rst = 1'b1;
      bus.if_req_i = 0; bus.if_addr_i = '0; bus.if_flush_i = 0;
      bus.ls_req_i = 0; bus.ls_we_i = 0; bus.ls_addr_i = '0;
      bus.ls_wdata_i = '0; bus.ls_wmask_i = '0;
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
      repeat (2) @(posedge clk);
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         phase = (cyc < 30) ? 0 : (cyc < 160) ? 1 : (cyc < NCYC - 60) ? 2 : 3;

         // reset: released at cycle 0, later pulsed mostly while a read is in flight
         if (cyc == 0) rst = 1'b0;
         else if (rst) begin
            if (rst_hold > 0) rst_hold--;
            else rst = 1'b0;
         end else if (phase == 2 && m_busy && $urandom_range(0, 30) == 0) begin
            rst = 1'b1; rst_hold = $urandom_range(0, 1);
         end

         if (if_acc_f) if_pend = 0;
         if (ls_acc_f) ls_pend = 0;
         if_acc_f = 0; ls_acc_f = 0;

         // IFU
         bus.if_flush_i = (phase == 2) && ($urandom_range(0, 5) == 0);
         if (!if_pend && (phase == 0 || phase == 1 || (phase == 2 && $urandom_range(0, 2) == 0))) begin
            a = {$urandom, $urandom}; a[1:0] = 2'b00;
            if (first_fetch) begin a = 64'h8000_0004; first_fetch = 0; end
            if_pend = 1; bus.if_addr_i = a;
         end else if (if_pend && bus.if_flush_i && $urandom_range(0, 1) == 1) begin
            a = {$urandom, $urandom}; a[1:0] = 2'b00; bus.if_addr_i = a;
         end
         bus.if_req_i = if_pend;

         // LSU
         if (!ls_pend && (phase == 1 || (phase == 2 && $urandom_range(0, 2) == 0))) begin
            ls_pend = 1;
            a = {$urandom, $urandom}; a[2:0] = 3'b000;
            bus.ls_addr_i  = a;
            bus.ls_we_i    = $urandom_range(0, 1);
            bus.ls_wdata_i = {$urandom, $urandom};
            bus.ls_wmask_i = $urandom_range(0, 255);
            if (first_store) begin
               first_store = 0;
               bus.ls_we_i = 1; bus.ls_wdata_i = 64'hAB; bus.ls_wmask_i = 8'h0F;
            end
         end
         bus.ls_req_i = ls_pend;

         // memory: one transaction at a time, random grant/response delays,
         // stray gnt/rvalid when nothing is in flight
         bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
         bus.mem_rdata_i = {$urandom, $urandom};
         if (m_busy) begin
            if (m_cnt == 0) begin
               bus.mem_rvalid_i = 1; bus.mem_rdata_i = mem_data(m_addr); m_busy = 0;
            end else m_cnt--;
         end else begin
            if (bus.mem_req_o) begin
               if (g_cnt == 0) begin
                  bus.mem_gnt_i = 1; m_busy = 1; m_addr = bus.mem_addr_o;
                  m_cnt = (phase == 0) ? 0 : $urandom_range(0, 3);
                  g_cnt = gnt_delay(phase);
               end else g_cnt--;
            end else if (phase == 2) begin
               bus.mem_gnt_i = ($urandom_range(0, 4) == 0);
            end
            if (phase == 2 && !bus.mem_gnt_i) bus.mem_rvalid_i = ($urandom_range(0, 4) == 0);
         end
      end

      @(negedge clk);
      #1;
      chk("drain_idle", busy, 0);
      chk("drain_queue", exp_q.size(), 0);
      chk("first_fetch_data", first_if_data, 32'h1111_2222);
      chk("first_fetch_latency", first_lat, 3);
      chk("ifu_progress", if_done > 20, 1);
      chk("lsu_progress", ls_done > 20, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/core_mem_arb.md
CORE_MEM_ARB -- requirements
Module: core_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 64, width of all address buses SHALL be ADDR_W.
REQ-002 Parameter STARVE_MAX, default 4, max consecutive contested LSU grants before IFU SHALL win.
REQ-003 clk  input  1  single core clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 if_req_i  input  1  IFU fetch request, held until if_ready_o.
REQ-006 if_addr_i  input  ADDR_W  fetch address.
REQ-007 if_flush_i  input  1  discard any outstanding fetch (taken branch/jump).
REQ-008 if_ready_o  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid_o  output  1  one-cycle pulse, if_rdata_o valid.
REQ-010 if_rdata_o  output  32  fetched instruction.
REQ-011 ls_req_i, ls_we_i  input  1 each  LSU request, write-enable; held until ls_ready_o.
REQ-012 ls_addr_i  input  ADDR_W; ls_wdata_i  input  64; ls_wmask_i  input  8  byte enables.
REQ-013 ls_ready_o  output  1  LSU request accepted this cycle.
REQ-014 ls_rvalid_o  output  1  one-cycle pulse: load data valid or store complete.
REQ-015 ls_rdata_o  output  64  load data (raw, unextended).
REQ-016 mem_req_o, mem_we_o  output  1 each; mem_addr_o  output  ADDR_W; mem_wdata_o  output  64; mem_wmask_o  output  8.
REQ-017 mem_gnt_i  input  1  memory accepted mem_req_o this cycle.
REQ-018 mem_rvalid_i  input  1  read data / write ack; mem_rdata_i  input  64.

Function
REQ-019 FSM states SHALL be IDLE, REQ (mem_req_o held), WAIT (awaiting mem_rvalid_i); one transaction outstanding max.
REQ-020 In IDLE with any request, winner SHALL get ready_o high combinationally that cycle; address, we, wdata, wmask, owner latched; next state REQ.
REQ-021 Priority: LSU wins over IFU, except IFU SHALL win when streak counter == STARVE_MAX.
REQ-022 Streak counter (3 bits) SHALL increment on LSU grant while if_req_i high, clear on any IFU grant, saturate at STARVE_MAX.
REQ-023 IFU SHALL NOT be granted in a cycle where if_flush_i is high.
REQ-024 In REQ, mem_req_o=1 and mem_* outputs SHALL show latched values unchanged until mem_gnt_i; on gnt go WAIT, mem_req_o=0 next cycle.
REQ-025 For reads mem_we_o=0, mem_wdata_o=0, mem_wmask_o=0; IFU transactions always reads.
REQ-026 In WAIT, on mem_rvalid_i: owner's rvalid_o SHALL pulse next cycle with registered data, state to IDLE; new accept possible that same next cycle.
REQ-027 IFU data: if_rdata_o = mem_rdata_i[63:32] when latched addr[2]=1, else [31:0].
REQ-028 Minimum latency accept->rvalid_o = 3 cycles (gnt in first REQ cycle, rvalid_i one cycle later).
REQ-029 if_flush_i while an IFU transaction is in REQ or WAIT SHALL set a drop flag; transaction still completes on bus; if_rvalid_o suppressed; flag cleared on completion.
REQ-030 if_flush_i in IDLE or during LSU transaction SHALL have no effect on state.
REQ-031 mem_rvalid_i in IDLE or REQ SHALL be ignored; mem_gnt_i outside REQ ignored.
REQ-032 rdata_o outputs SHALL hold last value between pulses.

Reset
REQ-033 rst high at a clock edge SHALL force IDLE, streak=0, drop=0, all outputs 0 next cycle, regardless of outstanding transaction.
REQ-034 After reset deassert, first request SHALL be acceptable in the first cycle rst is low.

Verification
REQ-035 IFU-only fetch addr 0x8000_0004, gnt immediate, rdata 0x1111_2222_3333_4444 -> if_rvalid_o 3 cycles after accept, if_rdata_o=0x1111_2222.
REQ-036 Simultaneous if_req/ls_req (store, wmask 0x0F, wdata 0xAB) -> ls_ready_o first, mem_we_o=1, mem_wmask_o=0x0F; IFU granted after ls_rvalid_o.
REQ-037 LSU asserted continuously with IFU pending -> 4 LSU grants then IFU grant, streak returns to 0.
REQ-038 Flush in WAIT of fetch -> no if_rvalid_o, FSM returns IDLE after mem_rvalid_i, next fetch proceeds normally.
REQ-039 mem_gnt_i held low 5 cycles -> mem_addr_o/mem_req_o stable all 5 cycles; completion normal afterwards.
REQ-040 rst asserted in WAIT -> all outputs 0 next cycle; late mem_rvalid_i ignored, no rvalid_o pulse.
